signed_serial_multiplier: RTL and testbench

- Parametrised signed two's-complement multiplier with bit-serial operand load and result unload, WIDTH x WIDTH -> 2*WIDTH.
- Operands shift in MSB-first on independent X and Y pins; the core runs a WIDTH-cycle sign-magnitude shift-add multiply with final sign correction; the product shifts out MSB-first.
- Successor to the fixed 12-bit signed multiplier: it adds a width parameter, separate X/Y load, a busy flag, a zero-result sign fix and a cleanly sequenced FSM.

---
 rtl/signed_serial_multiplier.sv | 129 ++++++++++++
 tb/tb_signed_serial_multiplier.sv | 131 +++++++++++++
 2 files changed

// File: rtl/signed_serial_multiplier.sv
// signed_serial_multiplier: WIDTH x WIDTH signed multiply, serial MSB-first load/unload, sign-magnitude shift-add core
// Ports: clk, rst (async active-low); x_in/sx/fx and y_in/sy/fy load operands; mul starts;
// busy while not idle; done with z_out shows product MSB; sz shifts product; fz pulses after last bit.
// SIGNED_MUL_TEST_EN adds x_test/y_test/z_test observation ports.
module signed_serial_multiplier #(
  parameter int WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic x_in,
  input  logic sx,
  output logic fx,
  input  logic y_in,
  input  logic sy,
  output logic fy,
  input  logic mul,
  output logic done,
  output logic busy,
  input  logic sz,
  output logic z_out,
  output logic fz
`ifdef SIGNED_MUL_TEST_EN
  ,
  output logic [WIDTH-1:0]   x_test,
  output logic [WIDTH-1:0]   y_test,
  output logic [2*WIDTH-1:0] z_test
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int ZW = $clog2(2 * WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MULT, SIGN, OUT} state_t;
  state_t state;
  logic [WIDTH-1:0] x_reg, y_reg, mcand, mplier, acc, x_mag, y_mag;
  logic [CW-1:0] xcnt, ycnt, cnt;
  logic [ZW-1:0] zcnt;
  logic [2*WIDTH-1:0] z_reg, prod;
  logic [WIDTH:0] sum;
  logic neg;
  always_comb begin
    x_mag = x_reg[WIDTH-1] ? -x_reg : x_reg;
    y_mag = y_reg[WIDTH-1] ? -y_reg : y_reg;
    sum = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    prod = {acc, mplier};
  end
  assign z_out = done & z_reg[2*WIDTH-1];
`ifdef SIGNED_MUL_TEST_EN
  assign x_test = x_reg;
  assign y_test = y_reg;
  assign z_test = z_reg;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x_reg <= '0;
      y_reg <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      z_reg <= '0;
      xcnt <= '0;
      ycnt <= '0;
      cnt <= '0;
      zcnt <= '0;
      neg <= 1'b0;
      fx <= 1'b0;
      fy <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      fz <= 1'b0;
    end else begin
      fz <= 1'b0;
      case (state)
        IDLE: begin
          if (mul && fx && fy) begin
            mcand <= x_mag;
            mplier <= y_mag;
            neg <= x_reg[WIDTH-1] ^ y_reg[WIDTH-1];
            acc <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= MULT;
          end else begin
            if (sx && !fx) begin
              x_reg <= {x_reg[WIDTH-2:0], x_in};
              xcnt <= xcnt + 1'b1;
              fx <= xcnt == CW'(WIDTH - 1);
            end
            if (sy && !fy) begin
              y_reg <= {y_reg[WIDTH-2:0], y_in};
              ycnt <= ycnt + 1'b1;
              fy <= ycnt == CW'(WIDTH - 1);
            end
          end
        end
        MULT: begin
          // carry out of the add lands in the acc MSB as the pair shifts right
          acc <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          z_reg <= (neg && |prod) ? -prod : prod;
          done <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          if (sz) begin
            z_reg <= {z_reg[2*WIDTH-2:0], 1'b0};
            zcnt <= zcnt + 1'b1;
            if (zcnt == ZW'(2 * WIDTH - 1)) begin
              fz <= 1'b1;
              fx <= 1'b0;
              fy <= 1'b0;
              done <= 1'b0;
              busy <= 1'b0;
              xcnt <= '0;
              ycnt <= '0;
              cnt <= '0;
              zcnt <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_serial_multiplier.sv
// tb_signed_serial_multiplier: directed vector bench for signed_serial_multiplier
module tb_signed_serial_multiplier;
  localparam int W = 12;
  logic clk = 1'b0, rst = 1'b0, x_in = 1'b0, sx = 1'b0, y_in = 1'b0, sy = 1'b0, mul = 1'b0, sz = 1'b0;
  logic fx, fy, done, busy, z_out, fz;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] z;
    string          nm;
  } vec_t;
  vec_t v[9];
  signed_serial_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .sx(sx), .fx(fx), .y_in(y_in), .sy(sy), .fy(fy),
    .mul(mul), .done(done), .busy(busy), .sz(sz), .z_out(z_out), .fz(fz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic load(input logic [W-1:0] x, input logic [W-1:0] y, input logic dx, input logic dy);
    for (int i = W - 1; i >= 0; i--) begin
      x_in = x[i];
      y_in = y[i];
      sx = dx;
      sy = dy;
      @(negedge clk);
    end
    sx = 1'b0;
    sy = 1'b0;
  endtask
  task automatic go(input logic [2*W-1:0] exp, input string nm);
    int n;
    logic [2*W-1:0] z;
    logic early;
    mul = 1'b1;
    @(negedge clk);
    mul = 1'b0;
    chk({nm, " busy"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, W + 1);
    repeat (3) @(negedge clk);
    chk({nm, " done_hold"}, done, 1);
    early = 1'b0;
    for (int i = 2 * W - 1; i >= 0; i--) begin
      z[i] = z_out;
      early |= fz;
      sz = 1'b1;
      @(negedge clk);
    end
    sz = 1'b0;
    chk({nm, " product"}, z, exp);
    chk({nm, " fz_early"}, early, 0);
    chk({nm, " fz"}, fz, 1);
    chk({nm, " done_busy_clr"}, {done, busy, fx, fy}, 0);
    @(negedge clk);
    chk({nm, " fz_pulse"}, fz, 0);
  endtask
  initial begin
    v[0] = '{12'h005, 12'hFFD, 24'hFFFFF1, "5x-3"};
    v[1] = '{12'h800, 12'h800, 24'h400000, "min_x_min"};
    v[2] = '{12'h7FF, 12'h7FF, 24'h3FF001, "max_x_max"};
    v[3] = '{12'h000, 12'hFF9, 24'h000000, "0x-7"};
    v[4] = '{12'hFFF, 12'h001, 24'hFFFFFF, "-1x1"};
    v[5] = '{12'hFFB, 12'h007, 24'hFFFFDD, "-5x7"};
    v[6] = '{12'h800, 12'h7FF, 24'hC00800, "min_x_max"};
    v[7] = '{12'h3E8, 12'hC18, 24'hF0BDC0, "1000x-1000"};
    v[8] = '{12'hFFF, 12'hFFF, 24'h000001, "-1x-1"};
    repeat (2) @(negedge clk);
    chk("reset outputs", {fx, fy, done, busy, fz, z_out}, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      load(v[i].x, v[i].y, 1'b1, 1'b1);
      chk({v[i].nm, " full"}, {fx, fy}, 2'b11);
      go(v[i].z, v[i].nm);
    end
    // mul with only X loaded is ignored
    load(12'h003, 12'h000, 1'b1, 1'b0);
    chk("x_only full", {fx, fy}, 2'b10);
    mul = 1'b1;
    @(negedge clk);
    mul = 1'b0;
    @(negedge clk);
    chk("x_only no start", busy, 0);
    load(12'h000, 12'h004, 1'b0, 1'b1);
    go(24'h00000C, "late_y");
    // mul on the edge fx completes is not accepted
    load(12'h000, 12'h006, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) begin
      x_in = 1'(12'h002 >> i);
      sx = 1'b1;
      mul = (i == 0);
      @(negedge clk);
    end
    sx = 1'b0;
    mul = 1'b0;
    chk("mul_on_fill busy", busy, 0);
    // mul with sx while full: shift ignored, start accepted
    sx = 1'b1;
    x_in = 1'b1;
    go(24'h00000C, "mul_with_sx");
    sx = 1'b0;
    // reset during MULT aborts everything
    load(12'h0FF, 12'h0FF, 1'b1, 1'b1);
    mul = 1'b1;
    @(negedge clk);
    mul = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort outputs", {fx, fy, done, busy, fz, z_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort idle", {busy, done}, 0);
    load(12'h003, 12'h004, 1'b1, 1'b1);
    go(24'h00000C, "after_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
